// File: rtl/dp_bsr_pkg.sv
// rtl/dp_bsr_pkg.sv - shared types and helpers for the boundary scan register chain
package dp_bsr_pkg;

  typedef enum logic [1:0] {
    BSR_NORMAL = 2'b00,
    BSR_EXTEST = 2'b01,
    BSR_SAFE   = 2'b10
  } bsr_mode_t;

  // Counter must represent 0..N+1, where N+1 flags an overshift
  function automatic int bsr_cnt_width(input int n);
    return $clog2(n + 2);
  endfunction

endpackage

// File: rtl/dp_bsc_cell.sv
// rtl/dp_bsc_cell.sv - single boundary scan cell with capture/shift and update stages
module dp_bsc_cell #(
  parameter logic UPD_RST = 1'b0
) (
  input  logic iclk,
  input  logic resetn,
  input  logic cap_en,
  input  logic shift_en,
  input  logic upd_en,
  input  logic p_in,
  input  logic s_in,
  output logic cap,
  output logic upd
);

  logic cap_d, cap_q;
  logic upd_d, upd_q;

  always_comb begin
    cap_d = cap_q;
    if (cap_en) begin
      cap_d = shift_en ? s_in : p_in;
    end
  end

  // Update always samples the pre-edge capture value
  always_comb begin
    upd_d = upd_q;
    if (upd_en) begin
      upd_d = cap_q;
    end
  end

  always_ff @(posedge iclk or negedge resetn) begin
    if (!resetn) begin
      cap_q <= 1'b0;
      upd_q <= UPD_RST;
    end else begin
      cap_q <= cap_d;
      upd_q <= upd_d;
    end
  end

  assign cap = cap_q;
  assign upd = upd_q;

endmodule

// File: rtl/dp_bsr_chain.sv
// rtl/dp_bsr_chain.sv - N-cell boundary scan register with shift counting and strict update check
module dp_bsr_chain
  import dp_bsr_pkg::*;
#(
  parameter int           N          = 8,
  parameter logic [N-1:0] SAFE_VALUE = '0,
  parameter bit           STRICT_UPD = 1'b1,
  localparam int          CW         = bsr_cnt_width(N)
) (
  input  logic          iclk,
  input  logic          resetn,
  input  logic [N-1:0]  p_data_in,
  output logic [N-1:0]  p_data_out,
  input  logic          s_data_in,
  output logic          s_data_out,
  input  logic [1:0]    mode,
  input  logic          shift_dr,
  input  logic          clk_dr,
  input  logic          update_dr,
  output logic [CW-1:0] shift_cnt,
  output logic          upd_ok,
  output logic          upd_err
);

  localparam logic [CW-1:0] CNT_FULL = CW'(N);
  localparam logic [CW-1:0] CNT_MAX  = CW'(N + 1);

  logic [N:0]    chain;
  logic [N-1:0]  cap_vec;
  logic [N-1:0]  upd_vec;
  logic          accept;
  logic          upd_en;
  logic [CW-1:0] cnt_d, cnt_q;
  logic          upd_ok_d, upd_ok_q;
  logic          upd_err_d, upd_err_q;

  // chain[i+1] feeds cell i; the top of the chain is the TDI side
  assign chain[N] = s_data_in;

  for (genvar i = 0; i < N; i++) begin : g_cell
    dp_bsc_cell #(
      .UPD_RST (SAFE_VALUE[i])
    ) u_cell (
      .iclk     (iclk),
      .resetn   (resetn),
      .cap_en   (clk_dr),
      .shift_en (shift_dr),
      .upd_en   (upd_en),
      .p_in     (p_data_in[i]),
      .s_in     (chain[i+1]),
      .cap      (cap_vec[i]),
      .upd      (upd_vec[i])
    );
    assign chain[i] = cap_vec[i];
  end

  assign accept = !STRICT_UPD || (cnt_q == CNT_FULL);
  assign upd_en = update_dr && accept;

  // An update restarts the count; a shift on the same edge counts as the first new bit
  always_comb begin
    cnt_d = cnt_q;
    if (clk_dr) begin
      if (shift_dr) begin
        cnt_d = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
      end else begin
        cnt_d = '0;
      end
    end
    if (update_dr) begin
      cnt_d = (clk_dr && shift_dr) ? CW'(1) : '0;
    end
  end

  always_comb begin
    upd_ok_d  = update_dr && accept;
    upd_err_d = update_dr && !accept;
  end

  always_ff @(posedge iclk or negedge resetn) begin
    if (!resetn) begin
      cnt_q     <= '0;
      upd_ok_q  <= 1'b0;
      upd_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      upd_ok_q  <= upd_ok_d;
      upd_err_q <= upd_err_d;
    end
  end

  always_comb begin
    p_data_out = SAFE_VALUE;
    case (bsr_mode_t'(mode))
      BSR_NORMAL: p_data_out = p_data_in;
      BSR_EXTEST: p_data_out = upd_vec;
      default:    p_data_out = SAFE_VALUE;
    endcase
  end

  assign s_data_out = cap_vec[0];
  assign shift_cnt  = cnt_q;
  assign upd_ok     = upd_ok_q;
  assign upd_err    = upd_err_q;

endmodule

// File: tb/tb_dp_bsr_chain.sv
// tb/tb_dp_bsr_chain.sv - self-checking bench for dp_bsr_chain (N=8, SAFE_VALUE=8'hA5, strict)
module tb_dp_bsr_chain;

  localparam logic [7:0] SAFE = 8'hA5;

  logic       iclk;
  logic       resetn;
  logic [7:0] p_data_in;
  logic [7:0] p_data_out;
  logic       s_data_in;
  logic       s_data_out;
  logic [1:0] mode;
  logic       shift_dr;
  logic       clk_dr;
  logic       update_dr;
  logic [3:0] shift_cnt;
  logic       upd_ok;
  logic       upd_err;

  dp_bsr_chain #(
    .N          (8),
    .SAFE_VALUE (SAFE),
    .STRICT_UPD (1'b1)
  ) dut (
    .iclk       (iclk),
    .resetn     (resetn),
    .p_data_in  (p_data_in),
    .p_data_out (p_data_out),
    .s_data_in  (s_data_in),
    .s_data_out (s_data_out),
    .mode       (mode),
    .shift_dr   (shift_dr),
    .clk_dr     (clk_dr),
    .update_dr  (update_dr),
    .shift_cnt  (shift_cnt),
    .upd_ok     (upd_ok),
    .upd_err    (upd_err)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  typedef struct {
    logic       sout;
    logic [3:0] cnt;
    logic [7:0] pout;
    logic       ok;
    logic       err;
  } exp_t;

  typedef struct {
    logic       cd;
    logic       sd;
    logic       ud;
    logic       si;
    logic [7:0] pi;
    logic       esout;
    logic [3:0] ecnt;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[$];

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] m_cap;
  logic [7:0] m_upd;
  logic [3:0] m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_total++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
  endtask

  task automatic model_reset();
    m_cap = 8'h00;
    m_upd = SAFE;
    m_cnt = 4'd0;
  endtask

  // Drive one cycle of strobes, predict the post-edge outputs, then compare them
  task automatic step(input logic cd, input logic sd, input logic ud, input logic si,
                      input logic [7:0] pi, input logic [1:0] md);
    exp_t e;
    logic [7:0] n_cap, n_upd;
    logic [3:0] n_cnt;
    logic acc;
    clk_dr = cd; shift_dr = sd; update_dr = ud; s_data_in = si; p_data_in = pi; mode = md;
    acc   = (m_cnt == 4'd8);
    n_cap = m_cap; n_upd = m_upd; n_cnt = m_cnt;
    if (cd) begin
      if (sd) begin
        n_cap = {si, m_cap[7:1]};
        n_cnt = (m_cnt >= 4'd9) ? 4'd9 : m_cnt + 4'd1;
      end else begin
        n_cap = pi;
        n_cnt = 4'd0;
      end
    end
    if (ud) begin
      if (acc) n_upd = m_cap;
      n_cnt = (cd && sd) ? 4'd1 : 4'd0;
    end
    e.sout = n_cap[0];
    e.cnt  = n_cnt;
    e.pout = (md == 2'd0) ? pi : (md == 2'd1) ? n_upd : SAFE;
    e.ok   = ud && acc;
    e.err  = ud && !acc;
    sb_q.push_back(e);
    m_cap = n_cap; m_upd = n_upd; m_cnt = n_cnt;
    @(posedge iclk);
    #1;
    clk_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
    e = sb_q.pop_front();
    check("sb_sout", s_data_out, e.sout);
    check("sb_cnt", shift_cnt, e.cnt);
    check("sb_pout", p_data_out, e.pout);
    check("sb_ok", upd_ok, e.ok);
    check("sb_err", upd_err, e.err);
  endtask

  task automatic shift_byte(input logic [7:0] v);
    for (int k = 0; k < 8; k++) step(1, 1, 0, v[k], 8'h00, 2'd1);
  endtask

  initial begin
    resetn = 1'b0; p_data_in = 8'h00; s_data_in = 1'b0; mode = 2'd1;
    shift_dr = 1'b0; clk_dr = 1'b0; update_dr = 1'b0;
    model_reset();
    #12;
    check("rst_pout", p_data_out, 8'hA5);
    check("rst_sout", s_data_out, 1'b0);
    check("rst_cnt", shift_cnt, 4'd0);
    check("rst_ok", upd_ok, 1'b0);
    check("rst_err", upd_err, 1'b0);
    resetn = 1'b1;
    @(posedge iclk); #1;

    // Capture 3C then shift out LSB first with zeros shifting in
    tbl.push_back('{cd:1, sd:0, ud:0, si:0, pi:8'h3C, esout:0, ecnt:4'd0});
    tbl.push_back('{cd:1, sd:1, ud:0, si:0, pi:8'h00, esout:0, ecnt:4'd1});
    tbl.push_back('{cd:1, sd:1, ud:0, si:0, pi:8'h00, esout:1, ecnt:4'd2});
    tbl.push_back('{cd:1, sd:1, ud:0, si:0, pi:8'h00, esout:1, ecnt:4'd3});
    tbl.push_back('{cd:1, sd:1, ud:0, si:0, pi:8'h00, esout:1, ecnt:4'd4});
    tbl.push_back('{cd:1, sd:1, ud:0, si:0, pi:8'h00, esout:1, ecnt:4'd5});
    tbl.push_back('{cd:1, sd:1, ud:0, si:0, pi:8'h00, esout:0, ecnt:4'd6});
    tbl.push_back('{cd:1, sd:1, ud:0, si:0, pi:8'h00, esout:0, ecnt:4'd7});
    tbl.push_back('{cd:1, sd:1, ud:0, si:0, pi:8'h00, esout:0, ecnt:4'd8});
    tbl.push_back('{cd:0, sd:1, ud:0, si:1, pi:8'hFF, esout:0, ecnt:4'd8});
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].cd, tbl[i].sd, tbl[i].ud, tbl[i].si, tbl[i].pi, 2'd1);
      check("tbl_sout", s_data_out, tbl[i].esout);
      check("tbl_cnt", shift_cnt, tbl[i].ecnt);
    end

    // Full-length shift of 96 then accepted update
    step(1, 0, 0, 0, 8'h00, 2'd1);
    shift_byte(8'h96);
    step(0, 0, 1, 0, 8'h00, 2'd1);
    check("upd96_pout", p_data_out, 8'h96);
    check("upd96_ok", upd_ok, 1'b1);
    step(0, 0, 0, 0, 8'h00, 2'd1);
    check("upd96_ok_pulse", upd_ok, 1'b0);

    // Short shift: rejected, UPD unchanged
    step(1, 0, 0, 0, 8'h00, 2'd1);
    for (int k = 0; k < 7; k++) step(1, 1, 0, 1, 8'h00, 2'd1);
    step(0, 0, 1, 0, 8'h00, 2'd1);
    check("short_err", upd_err, 1'b1);
    check("short_pout", p_data_out, 8'h96);
    check("short_cnt", shift_cnt, 4'd0);

    // Overshift saturates at N+1 and is rejected
    for (int k = 0; k < 10; k++) step(1, 1, 0, k[0], 8'h00, 2'd1);
    check("over_cnt", shift_cnt, 4'd9);
    step(0, 0, 1, 0, 8'h00, 2'd1);
    check("over_err", upd_err, 1'b1);
    check("over_pout", p_data_out, 8'h96);

    // Update and shift on the same edge: pre-edge CAP, count restarts at 1
    step(1, 0, 0, 0, 8'h00, 2'd1);
    shift_byte(8'h4D);
    step(1, 1, 1, 1, 8'h00, 2'd1);
    check("same_pout", p_data_out, 8'h4D);
    check("same_cnt", shift_cnt, 4'd1);
    check("same_ok", upd_ok, 1'b1);
    step(0, 0, 1, 0, 8'h00, 2'd1);
    check("b2b_err", upd_err, 1'b1);
    check("b2b_pout", p_data_out, 8'h4D);

    // Asynchronous reset mid-shift
    step(1, 0, 0, 0, 8'hFF, 2'd1);
    step(1, 1, 0, 1, 8'h00, 2'd1);
    step(1, 1, 0, 1, 8'h00, 2'd1);
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    check("arst_pout", p_data_out, SAFE);
    check("arst_sout", s_data_out, 1'b0);
    check("arst_cnt", shift_cnt, 4'd0);
    #2;
    resetn = 1'b1;
    step(0, 0, 0, 0, 8'h00, 2'd1);

    // Mode sweep is purely combinational
    p_data_in = 8'h5E;
    mode = 2'd0; #1; check("mode_normal", p_data_out, 8'h5E);
    mode = 2'd2; #1; check("mode_safe", p_data_out, SAFE);
    mode = 2'd3; #1; check("mode_rsvd", p_data_out, SAFE);
    mode = 2'd1; #1; check("mode_extest", p_data_out, SAFE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
